regfile_wport_arbiter: RTL

- Shares the single register-file write port between two write-back requesters: A (ALU/R-type, rd) and B (load/I-type, rt).
- Each requester has a one-entry holding slot with valid/ready handshake.
- A round-robin arbiter picks one slot per cycle and drives registered we/waddr/wdata, plus the select line for the 5-bit destination-address 2:1 mux.
- Sits between execute/memory write-back and the register file.

---
 rtl/regfile_wport_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/regfile_wport_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wport_arbiter
//
// Purpose:
//   Shares the single register-file write port between two write-back
//   requesters. Requester A carries ALU/R-type results (rd) and requester B
//   carries load/I-type results (rt). Each requester has a one-entry holding
//   slot with a valid/ready handshake. A round-robin arbiter picks at most one
//   slot per cycle and drives registered we/waddr/wdata, plus the select line
//   for the destination-address 2:1 mux. Writes to register 0 are accepted but
//   discarded and counted.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   a_valid   in   1   requester A has a write
//   a_ready   out  1   A slot can accept this cycle
//   a_addr    in   AW  A destination register
//   a_data    in   DW  A write data
//   b_valid   in   1   requester B has a write
//   b_ready   out  1   B slot can accept this cycle
//   b_addr    in   AW  B destination register
//   b_data    in   DW  B write data
//   we        out  1   register-file write enable (registered)
//   waddr     out  AW  register-file write address (registered)
//   wdata     out  DW  register-file write data (registered)
//   sel       out  1   destination mux select: 0 = A, 1 = B (registered)
//   busy      out  1   at least one slot occupied
//   drop_cnt  out  8   saturating count of discarded writes to register 0
// ---------------------------------------------------------------------------
module regfile_wport_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          sel,
    output logic          busy,
    output logic [7:0]    drop_cnt
);

    // Holding slots
    logic          r_a_full;
    logic [AW-1:0] r_a_addr;
    logic [DW-1:0] r_a_data;
    logic          r_b_full;
    logic [AW-1:0] r_b_addr;
    logic [DW-1:0] r_b_data;

    // Arbiter history: side of the last grant (0 = A, 1 = B)
    logic          r_last_gnt;

    // Registered write-port outputs
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic          r_sel;
    logic [7:0]    r_drop_cnt;

    // Combinational decode
    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_a_ready;
    logic          w_b_ready;
    logic          w_a_cap;
    logic          w_b_cap;
    logic          w_a_drop;
    logic          w_b_drop;
    logic [8:0]    w_drop_sum;
    logic [7:0]    w_drop_nxt;

    // Grant and ready decode; depends only on registered state so that
    // valid never reaches ready combinationally.
    always_comb begin
        w_gnt_a   = 1'b0;
        w_gnt_b   = 1'b0;
        w_a_ready = 1'b0;
        w_b_ready = 1'b0;
        // A wins a tie when B was granted last (or after reset).
        w_gnt_a   = r_a_full & (~r_b_full | r_last_gnt);
        w_gnt_b   = r_b_full & (~r_a_full | ~r_last_gnt);
        // A slot that is being drained this edge can be refilled at the same edge.
        w_a_ready = ~r_a_full | w_gnt_a;
        w_b_ready = ~r_b_full | w_gnt_b;
    end

    // Handshake classification: store real writes, drop writes to register 0.
    always_comb begin
        w_a_cap  = 1'b0;
        w_b_cap  = 1'b0;
        w_a_drop = 1'b0;
        w_b_drop = 1'b0;
        if (a_valid && w_a_ready) begin
            if (a_addr != {AW{1'b0}}) begin
                w_a_cap = 1'b1;
            end else begin
                w_a_drop = 1'b1;
            end
        end else begin
            w_a_cap  = 1'b0;
            w_a_drop = 1'b0;
        end
        if (b_valid && w_b_ready) begin
            if (b_addr != {AW{1'b0}}) begin
                w_b_cap = 1'b1;
            end else begin
                w_b_drop = 1'b1;
            end
        end else begin
            w_b_cap  = 1'b0;
            w_b_drop = 1'b0;
        end
    end

    // Saturating drop counter next value; both sides may drop in one cycle,
    // so the 9-bit sum overflows only past 255 and clamps there.
    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt} + {8'd0, w_a_drop} + {8'd0, w_b_drop};
        w_drop_nxt = 8'd0;
        if (w_drop_sum[8]) begin
            w_drop_nxt = 8'hFF;
        end else begin
            w_drop_nxt = w_drop_sum[7:0];
        end
    end

    // Slot A: load on capture, otherwise empty when granted; contents are
    // frozen while full and not granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_full <= 1'b0;
            r_a_addr <= {AW{1'b0}};
            r_a_data <= {DW{1'b0}};
        end else if (w_a_cap) begin
            r_a_full <= 1'b1;
            r_a_addr <= a_addr;
            r_a_data <= a_data;
        end else if (w_gnt_a) begin
            r_a_full <= 1'b0;
        end
    end

    // Slot B: same behaviour as slot A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_full <= 1'b0;
            r_b_addr <= {AW{1'b0}};
            r_b_data <= {DW{1'b0}};
        end else if (w_b_cap) begin
            r_b_full <= 1'b1;
            r_b_addr <= b_addr;
            r_b_data <= b_data;
        end else if (w_gnt_b) begin
            r_b_full <= 1'b0;
        end
    end

    // Write port registers and round-robin history. Without a grant only we
    // drops; address, data and select keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_waddr    <= {AW{1'b0}};
            r_wdata    <= {DW{1'b0}};
            r_sel      <= 1'b0;
            r_last_gnt <= 1'b1;
        end else if (w_gnt_a) begin
            r_we       <= 1'b1;
            r_waddr    <= r_a_addr;
            r_wdata    <= r_a_data;
            r_sel      <= 1'b0;
            r_last_gnt <= 1'b0;
        end else if (w_gnt_b) begin
            r_we       <= 1'b1;
            r_waddr    <= r_b_addr;
            r_wdata    <= r_b_data;
            r_sel      <= 1'b1;
            r_last_gnt <= 1'b1;
        end else begin
            r_we       <= 1'b0;
        end
    end

    // Register-0 drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else begin
            r_drop_cnt <= w_drop_nxt;
        end
    end

    assign a_ready  = w_a_ready;
    assign b_ready  = w_b_ready;
    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign sel      = r_sel;
    assign busy     = r_a_full | r_b_full;
    assign drop_cnt = r_drop_cnt;

endmodule
